// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation controller: FSM states, fail codes,
// byte-lane strobes and the default console/status addresses and magic values.
// Pure declarations; no logic, no latency, no flow control.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_PEND = 2'd1,
        W_PEND = 2'd2
    } fsm_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_FAIL_VAL = 2'd1;
    localparam logic [1:0] FC_WDOG     = 2'd2;
    localparam logic [1:0] FC_UNKNOWN  = 2'd3;

    // Console byte lanes: one 32-bit word per strobe nibble, char in its low byte
    localparam logic [15:0] STRB_LANE0 = 16'h000F;
    localparam logic [15:0] STRB_LANE1 = 16'h00F0;
    localparam logic [15:0] STRB_LANE2 = 16'h0F00;
    localparam logic [15:0] STRB_LANE3 = 16'hF000;

    // Status word lanes: low or high 64-bit half of the 128-bit beat
    localparam logic [15:0] STRB_STAT_LO = 16'h00FF;
    localparam logic [15:0] STRB_STAT_HI = 16'hFF00;

    localparam logic [31:0] DEF_CON_ADDR  = 32'h9000_0000;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h9000_0010;
    localparam logic [63:0] DEF_PASS_VAL  = 64'h4_4433_3222;
    localparam logic [63:0] DEF_FAIL_VAL  = 64'h23_8234_8720;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
    } aw_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } w_t;

    // Returns {hit, char}: hit only for an exact single-lane console strobe
    function automatic logic [8:0] con_lane(input logic [15:0] strb, input logic [127:0] data);
        logic [8:0] res;
        res = '0;
        case (strb)
            STRB_LANE0: res = {1'b1, data[7:0]};
            STRB_LANE1: res = {1'b1, data[39:32]};
            STRB_LANE2: res = {1'b1, data[71:64]};
            STRB_LANE3: res = {1'b1, data[103:96]};
            default:    res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sim_ctrl_char_fifo.sv
// Console character FIFO, DEPTH entries (power of 2), 8-bit data, pointer-with-wrap-bit full/empty.
// Latency: pushed char visible at head the cycle after the push (no bypass).
// Backpressure: push while full is dropped (drop pulses) unless a pop happens the same cycle.
module sim_ctrl_char_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] head_dat,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;
    assign head_dat = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the FIFO
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/sim_ctrl_monitor.sv
// Snoops AXI AW/W, decodes single-beat console/status writes, buffers chars, flags pass/fail, optional retire watchdog.
// Latency: decode registered one cycle after the completing handshake; char/status effect one cycle later.
// Backpressure: never stalls the bus; console drains via con_valid/con_ready, overflow drops and sets con_ovf.
// Optional watchdog enabled by defining SIM_CTRL_WATCHDOG_EN.
module sim_ctrl_monitor
    import sim_ctrl_pkg::*;
#(
    parameter logic [31:0] CON_ADDR    = DEF_CON_ADDR,
    parameter logic [31:0] STAT_ADDR   = DEF_STAT_ADDR,
    parameter logic [63:0] PASS_VAL    = DEF_PASS_VAL,
    parameter logic [63:0] FAIL_VAL    = DEF_FAIL_VAL,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          WDOG_WINDOW = 50000
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         biu_pad_awvalid,
    input  logic         biu_pad_awready,
    input  logic [39:0]  biu_pad_awaddr,
    input  logic [3:0]   biu_pad_awlen,
    input  logic         biu_pad_wvalid,
    input  logic         biu_pad_wready,
    input  logic [127:0] biu_pad_wdata,
    input  logic [15:0]  biu_pad_wstrb,
    input  logic         biu_pad_wlast,
    input  logic         core0_pad_retire,
    output logic         con_valid,
    input  logic         con_ready,
    output logic [7:0]   con_char,
    output logic         con_ovf,
    output logic         sim_done,
    output logic         sim_pass,
    output logic         sim_fail,
    output logic [1:0]   fail_code
);

    logic aw_hs;
    logic w_hs;
    aw_t  aw_cur;
    w_t   w_cur;

    assign aw_hs  = biu_pad_awvalid & biu_pad_awready;
    assign w_hs   = biu_pad_wvalid & biu_pad_wready;
    assign aw_cur = '{addr: biu_pad_awaddr[31:0], len: biu_pad_awlen};
    assign w_cur  = '{data: biu_pad_wdata, strb: biu_pad_wstrb, last: biu_pad_wlast};

    fsm_t         state;
    aw_t          aw_q;
    w_t           w_q;
    logic         dec_vld;
    logic [31:0]  dec_addr;
    logic [127:0] dec_data;
    logic [15:0]  dec_strb;

    // Pair AW with W in either order; a completed single-beat write is registered for decode
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            aw_q     <= '0;
            w_q      <= '0;
            dec_vld  <= 1'b0;
            dec_addr <= '0;
            dec_data <= '0;
            dec_strb <= '0;
        end else begin
            dec_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_hs && w_hs) begin
                        if (biu_pad_awlen == 4'd0) begin
                            dec_vld  <= 1'b1;
                            dec_addr <= aw_cur.addr;
                            dec_data <= w_cur.data;
                            dec_strb <= w_cur.strb;
                        end else if (!biu_pad_wlast) begin
                            // Burst started together with its first beat: swallow the rest
                            aw_q  <= aw_cur;
                            state <= A_PEND;
                        end
                    end else if (aw_hs) begin
                        aw_q  <= aw_cur;
                        state <= A_PEND;
                    end else if (w_hs) begin
                        w_q   <= w_cur;
                        state <= W_PEND;
                    end
                end
                A_PEND: begin
                    if (w_hs) begin
                        if (aw_q.len == 4'd0) begin
                            dec_vld  <= 1'b1;
                            dec_addr <= aw_q.addr;
                            dec_data <= w_cur.data;
                            dec_strb <= w_cur.strb;
                            state    <= IDLE;
                        end else if (biu_pad_wlast) begin
                            state <= IDLE;
                        end
                    end
                end
                W_PEND: begin
                    if (aw_hs) begin
                        if (biu_pad_awlen == 4'd0) begin
                            dec_vld  <= 1'b1;
                            dec_addr <= aw_cur.addr;
                            dec_data <= w_q.data;
                            dec_strb <= w_q.strb;
                            state    <= IDLE;
                        end else if (w_q.last || (w_hs && biu_pad_wlast)) begin
                            state <= IDLE;
                        end else begin
                            // Burst whose data led the address: skip beats up to wlast
                            aw_q  <= aw_cur;
                            state <= A_PEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [8:0]  lane;
    logic        con_push;
    logic        stat_hit;
    logic [63:0] stat_val;

    assign lane     = con_lane(dec_strb, dec_data);
    assign con_push = dec_vld && (dec_addr == CON_ADDR) && lane[8];
    assign stat_hit = dec_vld && (dec_addr == STAT_ADDR) &&
                      ((dec_strb == STRB_STAT_LO) || (dec_strb == STRB_STAT_HI));
    assign stat_val = (dec_strb == STRB_STAT_HI) ? dec_data[127:64] : dec_data[63:0];

    logic fifo_full;
    logic fifo_empty;
    logic fifo_drop;

    sim_ctrl_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_char_fifo (
        .clk      (clk),
        .rst_b    (rst_b),
        .push     (con_push),
        .push_dat (lane[7:0]),
        .pop      (con_ready),
        .head_dat (con_char),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    assign con_valid = !fifo_empty;

    logic wdog_expire;

`ifdef SIM_CTRL_WATCHDOG_EN
    localparam int WCW = $clog2(WDOG_WINDOW + 1);

    logic [WCW-1:0] wdog_cnt;
    logic [WCW-1:0] retire_cnt;
    logic           wdog_end;

    assign wdog_end    = (wdog_cnt == WCW'(WDOG_WINDOW));
    assign wdog_expire = wdog_end && (retire_cnt == '0);

    // Window counter 1..WDOG_WINDOW; a retire in the window's last cycle is not counted
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wdog_cnt   <= WCW'(1);
            retire_cnt <= '0;
        end else if (wdog_end) begin
            wdog_cnt   <= WCW'(1);
            retire_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (core0_pad_retire && (retire_cnt != '1)) retire_cnt <= retire_cnt + 1'b1;
        end
    end
`else
    assign wdog_expire = 1'b0;

    logic unused_retire;
    assign unused_retire = &{1'b0, core0_pad_retire};
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, biu_pad_awaddr[39:32], fifo_full};

    // Sticky verdict: first decision wins, status decode beats a same-cycle watchdog expiry
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sim_done  <= 1'b0;
            sim_pass  <= 1'b0;
            sim_fail  <= 1'b0;
            fail_code <= FC_NONE;
        end else if (!sim_done) begin
            if (stat_hit) begin
                sim_done <= 1'b1;
                if (stat_val == PASS_VAL) begin
                    sim_pass <= 1'b1;
                end else if (stat_val == FAIL_VAL) begin
                    sim_fail  <= 1'b1;
                    fail_code <= FC_FAIL_VAL;
                end else begin
                    sim_fail  <= 1'b1;
                    fail_code <= FC_UNKNOWN;
                end
            end else if (wdog_expire) begin
                sim_done  <= 1'b1;
                sim_fail  <= 1'b1;
                fail_code <= FC_WDOG;
            end
        end
    end

    // Sticky overflow flag for chars dropped at a full FIFO
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            con_ovf <= 1'b0;
        end else if (fifo_drop) begin
            con_ovf <= 1'b1;
        end
    end

endmodule
